// File: rtl/led_drv.sv
`default_nettype none
// ============================================================================
//  Module      : led_drv
//  Description : Single-pin indicator driver (LED/buzzer). Accepts CPU-side
//                commands for static off/on, continuous blink and counted
//                bursts, timed in ticks from a free-running prescaler.
//                Optional macro LED_PWM_EN adds brightness PWM during
//                on-phases using the latched duty value.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_drv #(
    parameter int TICK_DIV = 50000,
    parameter int PER_W    = 8,
    parameter int CNT_W    = 4,
    parameter int PWM_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [PER_W-1:0] cmd_on,
    input  logic [PER_W-1:0] cmd_off,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [PWM_W-1:0] cmd_duty,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int               PRE_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_ON     = 3'd1,
        S_BL_ON  = 3'd2,
        S_BL_OFF = 3'd3,
        S_BU_ON  = 3'd4,
        S_BU_OFF = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [PER_W-1:0] phase_q, phase_d;
    logic [PER_W-1:0] on_len_q, on_len_d;
    logic [PER_W-1:0] off_len_q, off_len_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             led_q, led_d;

    logic             w_accept;
    logic             w_tick;
    logic             w_on_state;
    logic [PER_W-1:0] w_on_eff;
    logic [PER_W-1:0] w_off_eff;

    assign w_accept  = cmd_valid & ~busy_q;
    assign w_tick    = (presc_q == TICK_LAST);
    // A zero-length phase would never expire, so it is promoted to one tick.
    assign w_on_eff  = (cmd_on  == '0) ? PER_ONE : cmd_on;
    assign w_off_eff = (cmd_off == '0) ? PER_ONE : cmd_off;

    // Next-state logic: command acceptance has priority over phase timing.
    always_comb begin
        state_d   = state_q;
        presc_d   = w_tick ? '0 : presc_q + 1'b1;
        phase_d   = phase_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (w_accept) begin
            // Restarting the prescaler makes the first phase exactly L ticks long.
            presc_d   = '0;
            on_len_d  = w_on_eff;
            off_len_d = w_off_eff;
            case (cmd_mode)
                2'b00: state_d = S_OFF;
                2'b01: state_d = S_ON;
                2'b10: begin
                    state_d = S_BL_ON;
                    phase_d = w_on_eff;
                end
                default: begin
                    if (cmd_count == '0) begin
                        state_d = S_OFF;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BU_ON;
                        phase_d = w_on_eff;
                        rem_d   = cmd_count;
                        busy_d  = 1'b1;
                    end
                end
            endcase
        end else if (w_tick && (state_q != S_OFF) && (state_q != S_ON)) begin
            if (phase_q != PER_ONE) begin
                phase_d = phase_q - 1'b1;
            end else begin
                case (state_q)
                    S_BL_ON: begin
                        state_d = S_BL_OFF;
                        phase_d = off_len_q;
                    end
                    S_BL_OFF: begin
                        state_d = S_BL_ON;
                        phase_d = on_len_q;
                    end
                    S_BU_ON: begin
                        rem_d = rem_q - 1'b1;
                        // Last pulse ends the burst directly; no trailing off-phase.
                        if (rem_q == CNT_ONE) begin
                            state_d = S_OFF;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_BU_OFF;
                            phase_d = off_len_q;
                        end
                    end
                    S_BU_OFF: begin
                        state_d = S_BU_ON;
                        phase_d = on_len_q;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign w_on_state = (state_d == S_ON) || (state_d == S_BL_ON) || (state_d == S_BU_ON);

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [PWM_W-1:0] duty_q, duty_d;

    // Brightness: pin follows the PWM compare of the counter value of the next cycle.
    always_comb begin
        pwm_d  = pwm_q + 1'b1;
        duty_d = w_accept ? cmd_duty : duty_q;
        led_d  = w_on_state && ((duty_d == '1) || (pwm_d < duty_d));
    end

    // Free-running PWM counter and latched duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q  <= '0;
            duty_q <= '0;
        end else begin
            pwm_q  <= pwm_d;
            duty_q <= duty_d;
        end
    end
`else
    logic w_unused_duty;
    assign w_unused_duty = ^cmd_duty;

    // Without PWM the pin is simply on in every on-state.
    always_comb begin
        led_d = w_on_state;
    end
`endif

    // State, timing counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            presc_q   <= '0;
            phase_q   <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

    assign cmd_ready = ~busy_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_drv
//  Description : Self-checking bench for led_drv. Directed scenarios followed
//                by random commands and resets, compared every cycle against
//                a waveform model computed from elapsed time since accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_drv;

    localparam int TD    = 4;
    localparam int PER_W = 8;
    localparam int CNT_W = 4;
    localparam int PWM_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [PER_W-1:0] cmd_on;
    logic [PER_W-1:0] cmd_off;
    logic [CNT_W-1:0] cmd_count;
    logic [PWM_W-1:0] cmd_duty;
    logic             led;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    led_drv #(
        .TICK_DIV (TD),
        .PER_W    (PER_W),
        .CNT_W    (CNT_W),
        .PWM_W    (PWM_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_on    (cmd_on),
        .cmd_off   (cmd_off),
        .cmd_count (cmd_count),
        .cmd_duty  (cmd_duty),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    int n_vec    = 0;
    int n_err    = 0;
    int pwm_high = 0;

    // Reference model: last accepted command and edges elapsed since it.
    bit m_known = 1'b0;
    int m_mode  = 0;
    int m_on    = 1;
    int m_off   = 1;
    int m_cnt   = 0;
    int m_duty  = 0;
    int m_t     = 1000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_exp(output bit e_led, output bit e_busy,
                                      output bit e_done, output bit e_known);
        int per, lon, hi_end;
        e_led   = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_known = 1'b1;
        lon = m_on * TD;
        per = (m_on + m_off) * TD;
        case (m_mode)
            1: e_led = 1'b1;
            2: e_led = ((m_t - 1) % per) < lon;
            3: begin
                if (m_cnt == 0) begin
                    e_done = (m_t == 1);
                end else begin
                    hi_end = (m_cnt - 1) * per + lon;
                    if (m_t <= hi_end) begin
                        e_busy = 1'b1;
                        e_led  = ((m_t - 1) % per) < lon;
                    end else begin
                        e_done = (m_t == hi_end + 1);
                    end
                end
            end
            default: e_led = 1'b0;
        endcase
`ifdef LED_PWM_EN
        if (e_led) begin
            if (m_duty == 0)       e_led   = 1'b0;
            else if (m_duty != 15) e_known = 1'b0;
        end
`endif
    endfunction

    // One clock: check the current cycle, drive the next inputs, advance the model.
    task automatic cycle(input bit r, input bit v, input int md, input int on,
                         input int off, input int cnt, input int duty);
        bit el, eb, ed, ek, acc;
        @(negedge clk);
        model_exp(el, eb, ed, ek);
        if (m_known) begin
            if (ek) check_eq("led", {31'd0, led}, {31'd0, el});
            else if (led === 1'b1) pwm_high++;
            check_eq("busy", {31'd0, busy}, {31'd0, eb});
            check_eq("done", {31'd0, done}, {31'd0, ed});
            check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, ~eb});
        end
        acc       = v && !eb;
        rst       = r;
        cmd_valid = v;
        cmd_mode  = md[1:0];
        cmd_on    = on[PER_W-1:0];
        cmd_off   = off[PER_W-1:0];
        cmd_count = cnt[CNT_W-1:0];
        cmd_duty  = duty[PWM_W-1:0];
        @(posedge clk);
        if (r) begin
            m_known = 1'b1;
            m_mode  = 0;
            m_t     = 1000;
        end else if (acc) begin
            m_mode = md;
            m_on   = (on  == 0) ? 1 : on;
            m_off  = (off == 0) ? 1 : off;
            m_cnt  = cnt;
            m_duty = duty;
            m_t    = 0;
        end
        if (m_t < 1000000) m_t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_on    = '0;
        cmd_off   = '0;
        cmd_count = '0;
        cmd_duty  = '0;

        // Reset, then quiet bus.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 0, 0, 0, 0);
        idle(12);

        // Blink 2/3 ticks, then override with off mid-phase.
        cycle(1'b0, 1'b1, 2, 2, 3, 0, 15);
        idle(45);
        cycle(1'b0, 1'b1, 0, 0, 0, 0, 15);
        idle(6);

        // Burst of 3 with 1/1 ticks; a mid-burst command must be ignored.
        cycle(1'b0, 1'b1, 3, 1, 1, 3, 15);
        idle(10);
        cycle(1'b0, 1'b1, 1, 5, 5, 0, 15);
        idle(20);

        // Burst count 0: only a done pulse.
        cycle(1'b0, 1'b1, 3, 1, 1, 0, 15);
        idle(6);

        // Zero-length phases behave as one tick.
        cycle(1'b0, 1'b1, 2, 0, 0, 0, 15);
        idle(20);

        // Burst of 5 aborted by reset during the second pulse.
        cycle(1'b0, 1'b1, 3, 1, 1, 5, 15);
        idle(9);
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 0);
        idle(8);

`ifdef LED_PWM_EN
        // Brightness: duty 4 gives 4 high cycles in every 16.
        cycle(1'b0, 1'b1, 1, 1, 1, 0, 4);
        pwm_high = 0;
        idle(32);
        check_eq("pwm_duty4_highs", pwm_high, 8);
        cycle(1'b0, 1'b1, 1, 1, 1, 0, 15);
        idle(20);
        cycle(1'b0, 1'b1, 1, 1, 1, 0, 0);
        idle(20);
`endif

        // Random commands and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 29) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 15)));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
